camera_qsys_led: RTL and testbench

- Avalon-MM write/read output PIO slave driving a 10-bit `out_port`, e.g. board LEDs or camera control strobes.
- Partner block to the input-PIO switch reader in the same Qsys system: the host writes the port here instead of reading it.
- Adds atomic bit set/clear registers.
- Adds a timed auto-clearing pulse mode from one shared down-counter, so software can flash bits without polling.

---
 rtl/camera_qsys_pio_pkg.sv | 11 +
 rtl/camera_qsys_led_if.sv | 20 ++
 rtl/camera_qsys_led_pulse_timer.sv | 44 ++++
 rtl/camera_qsys_led.sv | 88 ++++++++
 tb/tb_camera_qsys_led.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/camera_qsys_pio_pkg.sv
// rtl/camera_qsys_pio_pkg.sv - register map and bus width shared by the camera PIO blocks
package camera_qsys_pio_pkg;
   localparam int AVALON_WIDTH = 32;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
   localparam logic [2:0] ADDR_PULSE     = 3'd2;
   localparam logic [2:0] ADDR_COUNT     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
endpackage

// File: rtl/camera_qsys_led_if.sv
// rtl/camera_qsys_led_if.sv - Avalon-MM slave bus for the LED output PIO
interface camera_qsys_led_if;
   import camera_qsys_pio_pkg::*;

   logic [2:0]              address;
   logic                    chipselect;
   logic                    write_n;
   logic [AVALON_WIDTH-1:0] writedata;
   logic [AVALON_WIDTH-1:0] readdata;

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );
endinterface

// File: rtl/camera_qsys_led_pulse_timer.sv
// rtl/camera_qsys_led_pulse_timer.sv - shared down-counter holding the auto-clearing pulse mask
module camera_qsys_led_pulse_timer #(
   parameter int DATA_WIDTH = 10,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] bits,
   input  logic [CNT_WIDTH-1:0]  len,
   output logic [DATA_WIDTH-1:0] mask,
   output logic [CNT_WIDTH-1:0]  cnt,
   output logic [DATA_WIDTH-1:0] mask_next
);
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 trigger;

   assign trigger = load && (|bits) && (|len);

   // A retrigger on the expiry cycle wins, so old bits survive and are extended.
   always_comb begin
      mask_next = mask;
      cnt_next  = cnt;
      if (trigger) begin
         mask_next = mask | bits;
         cnt_next  = len;
      end else if (cnt > CNT_WIDTH'(1)) begin
         cnt_next = cnt - CNT_WIDTH'(1);
      end else if (cnt == CNT_WIDTH'(1)) begin
         cnt_next  = '0;
         mask_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask <= '0;
         cnt  <= '0;
      end else begin
         mask <= mask_next;
         cnt  <= cnt_next;
      end
   end
endmodule

// File: rtl/camera_qsys_led.sv
// rtl/camera_qsys_led.sv - output PIO with atomic set/clear and timed auto-clearing pulses
module camera_qsys_led
   import camera_qsys_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 10,
   parameter int                    CNT_WIDTH   = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   camera_qsys_led_if.slave      bus,
   output logic [DATA_WIDTH-1:0] out_port
);
   logic                  wr;
   logic [DATA_WIDTH-1:0] bits;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] data_next;
   logic [CNT_WIDTH-1:0]  pulse_len;
   logic [DATA_WIDTH-1:0] pulse_mask;
   logic [DATA_WIDTH-1:0] pulse_mask_next;
   logic [CNT_WIDTH-1:0]  pulse_cnt;
   logic                  unused_wdata;

   assign wr           = bus.chipselect & ~bus.write_n;
   assign bits         = bus.writedata[DATA_WIDTH-1:0];
   assign unused_wdata = &bus.writedata[AVALON_WIDTH-1:CNT_WIDTH];

   always_comb begin
      data_next = data_reg;
      if (wr) begin
         case (bus.address)
            ADDR_DATA:     data_next = bits;
            ADDR_OUTSET:   data_next = data_reg | bits;
            ADDR_OUTCLEAR: data_next = data_reg & ~bits;
            default:       data_next = data_reg;
         endcase
      end
   end

   camera_qsys_led_pulse_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_pulse_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (wr && (bus.address == ADDR_PULSE)),
      .bits      (bits),
      .len       (pulse_len),
      .mask      (pulse_mask),
      .cnt       (pulse_cnt),
      .mask_next (pulse_mask_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg  <= RESET_VALUE;
         pulse_len <= '0;
      end else begin
         data_reg <= data_next;
         if (wr && (bus.address == ADDR_PULSE_LEN)) begin
            pulse_len <= bus.writedata[CNT_WIDTH-1:0];
         end
      end
   end

   // Output is built from next-state values so it lines up with the register update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= RESET_VALUE;
      end else begin
         out_port <= data_next | pulse_mask_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else if (bus.chipselect) begin
         case (bus.address)
            ADDR_DATA:      bus.readdata <= AVALON_WIDTH'(data_reg);
            ADDR_PULSE_LEN: bus.readdata <= AVALON_WIDTH'(pulse_len);
            ADDR_PULSE:     bus.readdata <= AVALON_WIDTH'(pulse_mask);
            ADDR_COUNT:     bus.readdata <= AVALON_WIDTH'(pulse_cnt);
            default:        bus.readdata <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_camera_qsys_led.sv
// tb/tb_camera_qsys_led.sv - scoreboard bench for the LED output PIO
module tb_camera_qsys_led;
   logic       clk;
   logic       reset_n;
   logic [9:0] out_port;
   int         n_checks;
   int         n_errors;
   logic [31:0] rd_q[$];

   camera_qsys_led_if bus ();

   camera_qsys_led #(
      .DATA_WIDTH  (10),
      .CNT_WIDTH   (16),
      .RESET_VALUE (10'h000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 3'd0;
      bus.writedata  = 32'd0;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = addr;
      bus.writedata  = data;
      tick();
      bus_idle();
   endtask

   task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
      logic [31:0] e;
      rd_q.push_back(exp);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = addr;
      tick();
      bus_idle();
      e = rd_q.pop_front();
      check(tag, bus.readdata, e);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      bus_idle();
      reset_n = 1'b0;
      tick();
      tick();
      check("reset_out", 32'(out_port), 32'h0);
      check("reset_rd", bus.readdata, 32'h0);
      reset_n = 1'b1;
      tick();

      // 1: reset readback
      rd("rd_data_reset", 3'd0, 32'h0);
      check("out_idle", 32'(out_port), 32'h0);

      // 2: data, set, clear
      wr(3'd0, 32'hFFFF_F3F0);
      check("out_data", 32'(out_port), 32'h3F0);
      wr(3'd4, 32'h00F);
      check("out_set", 32'(out_port), 32'h3FF);
      wr(3'd5, 32'h300);
      check("out_clear", 32'(out_port), 32'h0FF);
      rd("rd_data", 3'd0, 32'h0FF);
      rd("rd_outset", 3'd4, 32'h0);
      rd("rd_addr7", 3'd7, 32'h0);

      // 3: single pulse of 5 cycles
      wr(3'd0, 32'h0);
      wr(3'd1, 32'd5);
      rd("rd_len", 3'd1, 32'd5);
      wr(3'd2, 32'h001);
      check("pulse_start", 32'(out_port), 32'h001);
      for (int i = 0; i < 6; i++) begin
         rd($sformatf("count_%0d", i), 3'd3, 32'(5 - i));
         check($sformatf("pulse_out_%0d", i), 32'(out_port), (i + 1 < 5) ? 32'h1 : 32'h0);
      end
      rd("rd_pulse_done", 3'd2, 32'h0);

      // 4: retrigger extends both bits
      wr(3'd1, 32'd4);
      wr(3'd2, 32'h001);
      tick();
      wr(3'd2, 32'h002);
      check("retrig_out0", 32'(out_port), 32'h003);
      rd("retrig_cnt", 3'd3, 32'd4);
      check("retrig_out1", 32'(out_port), 32'h003);
      rd("retrig_mask", 3'd2, 32'h003);
      check("retrig_out2", 32'(out_port), 32'h003);
      tick();
      check("retrig_out3", 32'(out_port), 32'h003);
      tick();
      check("retrig_expired", 32'(out_port), 32'h000);

      // 5: zero length pulse ignored
      wr(3'd1, 32'd0);
      wr(3'd2, 32'h3FF);
      check("zero_len_out", 32'(out_port), 32'h000);
      rd("zero_len_cnt", 3'd3, 32'h0);

      // 6: async reset during a long pulse
      wr(3'd1, 32'd100);
      wr(3'd2, 32'h200);
      check("long_out", 32'(out_port), 32'h200);
      for (int i = 0; i < 9; i++) tick();
      reset_n = 1'b0;
      #1;
      check("async_rst_out", 32'(out_port), 32'h000);
      tick();
      reset_n = 1'b1;
      tick();
      rd("post_rst_cnt", 3'd3, 32'h0);
      rd("post_rst_len", 3'd1, 32'h0);
      check("post_rst_out", 32'(out_port), 32'h000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
